// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, data word and arbiter FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_ctrl.sv
// Arbitrates one RAM port between instr fetch and data requesters; data first, streak-limited.
// Latency >= 2 cycles (grant, then serve until ACCESS); requesters stall on i/dwait until complete.
module mem_arbiter_ctrl
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

  arb_state_t  r_state;
  word_t       r_addr;
  word_t       r_store;
  logic        r_wr;
  logic        r_err;
  logic [3:0]  r_streak;
  logic [15:0] r_tcnt;

  logic w_dreq, w_starve, w_grant_d, w_grant_i;
  logic w_serve, w_held, w_done, w_busy, w_err_set;

  assign w_dreq    = dREN | dWEN;
  assign w_starve  = iREN & (r_streak >= STREAK_MAX);
  assign w_grant_d = (r_state == IDLE) & w_dreq & ~w_starve;
  assign w_grant_i = (r_state == IDLE) & iREN & ~w_grant_d;
  assign w_serve   = (r_state == SERVE_I) | (r_state == SERVE_D);
  // A served requester that drops its request aborts the access without completion.
  assign w_held    = ((r_state == SERVE_D) & w_dreq) | ((r_state == SERVE_I) & iREN);
  assign w_done    = w_held & (ramstate == ACCESS);
  assign w_busy    = w_serve & (ramstate == BUSY);
  assign w_err_set = w_busy & (r_tcnt >= TO_LAST);

  assign ramREN   = w_serve & ~r_wr;
  assign ramWEN   = w_serve & r_wr;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign iwait    = ~(w_done & (r_state == SERVE_I));
  assign dwait    = ~(w_done & (r_state == SERVE_D));
  assign iload    = ramload;
  assign dload    = ramload;
  assign err      = r_err | w_err_set;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_streak <= '0;
      r_tcnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state <= SERVE_D;
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
          end else if (w_grant_i) begin
            r_state <= SERVE_I;
            r_addr  <= iaddr;
            r_wr    <= 1'b0;
          end
        end
        default: begin
          if (!w_held || w_done) r_state <= IDLE;
        end
      endcase

      // Streak only grows while an instr fetch is actually being held off.
      if (w_done) begin
        if ((r_state == SERVE_D) && iREN) begin
          if (r_streak < STREAK_MAX) r_streak <= r_streak + 4'd1;
        end else begin
          r_streak <= '0;
        end
      end

      if (w_grant_d || w_grant_i) r_tcnt <= '0;
      else if (w_busy && (r_tcnt != 16'hFFFF)) r_tcnt <= r_tcnt + 16'd1;

      if (w_err_set) r_err <= 1'b1;
    end
  end

endmodule
